// File: rtl/typedefs_pkg.sv
// rtl/typedefs_pkg.sv - shared types for the unified-memory arbiter
package typedefs_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_D    = 2'd2,
        OWN_IF   = 2'd3
    } owner_t;

    localparam logic [3:0] FULL_WMASK = 4'b1111;

endpackage

// File: rtl/fetch_starve_ctr.sv
// rtl/fetch_starve_ctr.sv - saturating count of consecutive denied fetch cycles
module fetch_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority arbiter sharing one sync-read memory between
// the loader, the core data port and the core fetch port
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int AWIDTH       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ld_req,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_wdata,
    output logic              ld_gnt,

    input  logic              d_req,
    input  logic              d_wen,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,

    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,

    output logic              mem_en,
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [XLEN-1:0]   mem_rdata,

    output logic              stall
);

    import typedefs_pkg::*;

    owner_t owner;
    owner_t owner_nxt;
    logic   fetch_first;
    logic   fetch_denied;

    // Grants are masked during reset so nothing reaches the memory before release.
    always_comb begin
        ld_gnt = 1'b0;
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (!rst) begin
            if (ld_req) begin
                ld_gnt = 1'b1;
            end else if (if_req && fetch_first) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = ld_gnt | d_gnt | if_gnt;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (ld_gnt) begin
            mem_wen   = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_wmask = FULL_WMASK;
        end else if (d_gnt) begin
            mem_wen   = d_wen;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
        end else if (if_gnt) begin
            mem_addr  = {if_addr[AWIDTH-1:2], 2'b00};
        end
    end

    // Only read grants produce a response in the following cycle.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (d_gnt && !d_wen) begin
            owner_nxt = OWN_D;
        end else if (if_gnt) begin
            owner_nxt = OWN_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    assign fetch_denied = if_req && !if_gnt;

    fetch_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (fetch_denied),
        .clr      (!fetch_denied),
        .at_limit (fetch_first)
    );

    assign d_rvalid  = (owner == OWN_D);
    assign if_rvalid = (owner == OWN_IF);
    assign d_rdata   = mem_rdata;
    assign if_rdata  = mem_rdata;

    assign stall = !rst && (fetch_denied || (d_req && !d_gnt));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ld_req;
    logic [9:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        d_req;
    logic        d_wen;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_en;
    logic        mem_wen;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        stall;

    int total;
    int bad;

    logic [31:0] mem_arr [0:255];
    logic [7:0]  widx;

    mem_arbiter #(.XLEN(32), .AWIDTH(10), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read memory with byte enables.
    assign widx = mem_addr[9:2];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) mem_arr[widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_arr[widx];
            end
        end
    end

    task automatic set_idle();
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        if_req = 1'b0; if_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_req = 1'b1; ld_addr = 10'h3FC; ld_wdata = 32'hFFFF_FFFF;
        d_req = 1'b1; d_addr = 10'h004; if_req = 1'b1; if_addr = 10'h008;
        @(negedge clk); #1;
        total++;
        if ({ld_gnt, d_gnt, if_gnt, mem_en, stall} !== 5'b0) begin
            bad++;
            $display("FAIL reset_gnts: got %b want 00000", {ld_gnt, d_gnt, if_gnt, mem_en, stall});
        end
        total++;
        if ({d_rvalid, if_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_rvalid: got %b want 00", {d_rvalid, if_rvalid});
        end
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if ({d_rvalid, if_rvalid, ld_gnt, d_gnt, if_gnt, mem_en, mem_wen, stall} !== 8'b0 ||
                mem_addr !== 10'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
                bad++;
                $display("FAIL idle_after_reset[%0d]: flags=%b addr=%h wdata=%h wmask=%h want all 0",
                         i, {d_rvalid, if_rvalid, ld_gnt, d_gnt, if_gnt, mem_en, mem_wen, stall},
                         mem_addr, mem_wdata, mem_wmask);
            end
        end
    endtask

    task automatic test_load_fetch();
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 10'h010; ld_wdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if (ld_gnt !== 1'b1 || mem_en !== 1'b1 || mem_wen !== 1'b1 || mem_wmask !== 4'hF ||
            mem_addr !== 10'h010 || mem_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL ld_write: gnt=%b en=%b wen=%b wmask=%h addr=%h wdata=%h want 1 1 1 f 010 deadbeef",
                     ld_gnt, mem_en, mem_wen, mem_wmask, mem_addr, mem_wdata);
        end
        @(negedge clk);
        ld_req = 1'b0; if_req = 1'b1; if_addr = 10'h012;
        #1;
        total++;
        if (if_gnt !== 1'b1 || mem_addr !== 10'h010 || mem_wen !== 1'b0 || if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_issue: gnt=%b addr=%h wen=%b rvalid=%b want 1 010 0 0",
                     if_gnt, mem_addr, mem_wen, if_rvalid);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_data: if_rvalid=%b if_rdata=%h d_rvalid=%b want 1 deadbeef 0",
                     if_rvalid, if_rdata, d_rvalid);
        end
    endtask

    task automatic test_store_mask();
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 10'h020; ld_wdata = 32'h1122_3344;
        @(negedge clk);
        ld_req = 1'b0;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 10'h020; d_wdata = 32'h0000_00AB; d_wmask = 4'b0001;
        #1;
        total++;
        if (d_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_wmask !== 4'b0001 || mem_addr !== 10'h020) begin
            bad++;
            $display("FAIL store_issue: gnt=%b wen=%b wmask=%b addr=%h want 1 1 0001 020",
                     d_gnt, mem_wen, mem_wmask, mem_addr);
        end
        @(negedge clk);
        d_wen = 1'b0; d_wmask = 4'b0000;
        #1;
        total++;
        if (d_gnt !== 1'b1 || mem_wen !== 1'b0 || d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL load_issue: gnt=%b wen=%b rvalid=%b want 1 0 0", d_gnt, mem_wen, d_rvalid);
        end
        @(negedge clk);
        set_idle();
        #1;
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122_33AB || if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL masked_load: d_rvalid=%b d_rdata=%h if_rvalid=%b want 1 112233ab 0",
                     d_rvalid, d_rdata, if_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_d;
        bit prev_d;
        prev_d = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 10'h020; if_req = 1'b1; if_addr = 10'h010;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_d = ((i % 5) != 4);
            total++;
            if (d_gnt !== exp_d || if_gnt !== !exp_d || stall !== 1'b1) begin
                bad++;
                $display("FAIL starve_gnt[%0d]: d_gnt=%b if_gnt=%b stall=%b want %b %b 1",
                         i, d_gnt, if_gnt, stall, exp_d, !exp_d);
            end
            if (i > 0) begin
                total++;
                if (d_rvalid !== prev_d || if_rvalid !== !prev_d ||
                    (prev_d ? d_rdata : if_rdata) !== (prev_d ? 32'h1122_33AB : 32'hDEAD_BEEF)) begin
                    bad++;
                    $display("FAIL pipe_rdata[%0d]: d_rvalid=%b if_rvalid=%b d_rdata=%h if_rdata=%h prev_d=%b",
                             i, d_rvalid, if_rvalid, d_rdata, if_rdata, prev_d);
                end
            end
            prev_d = exp_d;
        end
        @(negedge clk);
        set_idle();
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL pipe_tail: if_rvalid=%b if_rdata=%h d_rvalid=%b want 1 deadbeef 0",
                     if_rvalid, if_rdata, d_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 10'h020; if_req = 1'b1; if_addr = 10'h010;
        #1;
        total++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL midrst_issue: d_gnt=%b want 1", d_gnt);
        end
        @(posedge clk); #1;
        set_idle();
        rst = 1'b1;
        #1;
        total++;
        if (d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_drop: d_rvalid=%b want 0", d_rvalid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        total++;
        if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release: d_rvalid=%b if_rvalid=%b want 0 0", d_rvalid, if_rvalid);
        end
        // A cleared counter needs four denied cycles before fetch wins again.
        d_req = 1'b1; if_req = 1'b1; d_addr = 10'h020; if_addr = 10'h010;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (d_gnt !== (i != 4) || if_gnt !== (i == 4)) begin
                bad++;
                $display("FAIL midrst_cnt[%0d]: d_gnt=%b if_gnt=%b want %b %b",
                         i, d_gnt, if_gnt, i != 4, i == 4);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 10'h040; ld_wdata = 32'hCAFE_0001;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 10'h020; if_req = 1'b1; if_addr = 10'h010;
        #1;
        total++;
        if (ld_gnt !== 1'b1 || d_gnt !== 1'b0 || if_gnt !== 1'b0 || stall !== 1'b1 || mem_addr !== 10'h040) begin
            bad++;
            $display("FAIL simul_gnt: ld=%b d=%b if=%b stall=%b addr=%h want 1 0 0 1 040",
                     ld_gnt, d_gnt, if_gnt, stall, mem_addr);
        end
        @(negedge clk);
        ld_req = 1'b0;
        // Counter already at 1, so fetch wins on the fourth cycle.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (d_gnt !== (i != 3) || if_gnt !== (i == 3)) begin
                bad++;
                $display("FAIL simul_cnt[%0d]: d_gnt=%b if_gnt=%b want %b %b",
                         i, d_gnt, if_gnt, i != 3, i == 3);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_loader_hog();
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 10'h030; ld_wdata = 32'h0BAD_F00D;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 10'h020; if_req = 1'b1; if_addr = 10'h010;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (ld_gnt !== 1'b1 || d_gnt !== 1'b0 || if_gnt !== 1'b0 || stall !== 1'b1) begin
                bad++;
                $display("FAIL hog[%0d]: ld=%b d=%b if=%b stall=%b want 1 0 0 1",
                         i, ld_gnt, d_gnt, if_gnt, stall);
            end
        end
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        total++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            bad++;
            $display("FAIL hog_saturate: if_gnt=%b d_gnt=%b want 1 0", if_gnt, d_gnt);
        end
        @(negedge clk);
        set_idle();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_rdata = 32'h0;
        set_idle();
        test_reset();
        test_load_fetch();
        test_store_mask();
        test_back_to_back();
        test_reset_mid_read();
        test_simultaneous();
        test_loader_hog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
